// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the registered ALU.
// Covers the opcode mnemonics and the sequencing states.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    kPASS_INPUTA    = 4'd0,
    kSHIFT_LEFT     = 4'd1,
    kSHIFT_RIGHT    = 4'd2,
    kKEEP_SMALLER   = 4'd3,
    kSHIFT_ON       = 4'd4,
    kADD            = 4'd5,
    kINPUTA_IS_ZERO = 4'd6,
    kPASS_INPUTB    = 4'd7,
    kINC_INPUTA     = 4'd8,
    kDEC_INPUTA     = 4'd9,
    kCLEAR          = 4'd10,
    kSUB            = 4'd11,
    kMUL            = 4'd12,
    kSHL_VAR        = 4'd13
  } op_mne;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    SHIFT = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Issue-side and result-side handshake bundle for alu_pipe.
interface alu_pipe_if #(parameter int WIDTH = 8);
  logic             IN_VALID;
  logic             IN_READY;
  logic [3:0]       OP;
  logic [WIDTH-1:0] INPUTA;
  logic [WIDTH-1:0] INPUTB;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT;
  logic [WIDTH-1:0] OUT_HI;
  logic             CARRY;
  logic             ZERO;
  logic             OVERFLOW;

  modport master (
    output IN_VALID, OP, INPUTA, INPUTB, OUT_READY,
    input  IN_READY, OUT_VALID, OUT, OUT_HI, CARRY, ZERO, OVERFLOW
  );

  modport slave (
    input  IN_VALID, OP, INPUTA, INPUTB, OUT_READY,
    output IN_READY, OUT_VALID, OUT, OUT_HI, CARRY, ZERO, OVERFLOW
  );
endinterface

// File: rtl/alu_pipe_comb.sv
// Single-cycle ALU datapath and flags.
// MUL yields 0 here; SHL_VAR yields A, which is the n=0 result.
module alu_comb
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      kPASS_INPUTA: res = a;
      kSHIFT_LEFT: begin
        res   = {a[MSB-1:0], 1'b0};
        carry = a[MSB];
      end
      kSHIFT_RIGHT: begin
        res   = {1'b0, a[MSB:1]};
        carry = a[0];
      end
      kKEEP_SMALLER: res = (b < a) ? b : a;
      kSHIFT_ON:     res = {a[MSB-1:0], b[0]};
      kADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      kINPUTA_IS_ZERO: ovf = (a == '0);
      kPASS_INPUTB:    res = b;
      kINC_INPUTA: begin
        res = a + ONE;
        ovf = !a[MSB] && res[MSB];
      end
      kDEC_INPUTA: begin
        res = a - ONE;
        ovf = a[MSB] && !res[MSB];
      end
      kSUB: begin
        // bit WIDTH of the widened difference is the unsigned borrow
        res   = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        ovf   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      kSHL_VAR: res = a;
      default:  res = '0;
    endcase
  end

  assign zero = (res == '0);

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU: 1-cycle ops via alu_comb, iterative MUL and variable left shift.
// state | meaning
// IDLE  | accepting ops when the output slot is free
// MUL   | shift-add multiply, one multiplier bit per cycle
// SHIFT | variable left shift, one bit per cycle
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       CLK,
  input  logic       RESET,
  alu_pipe_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  alu_state_t           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;

  logic                 in_ready;
  logic                 accept;
  logic [SHW-1:0]       sh_n;
  logic [2*WIDTH-1:0]   mul_sum;
  logic [WIDTH-1:0]     shl;
  logic [WIDTH-1:0]     c_res;
  logic                 c_carry, c_zero, c_ovf;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op    (bus.OP),
    .a     (bus.INPUTA),
    .b     (bus.INPUTB),
    .res   (c_res),
    .carry (c_carry),
    .zero  (c_zero),
    .ovf   (c_ovf)
  );

  assign in_ready = (state_q == IDLE) && (!valid_q || bus.OUT_READY);
  assign accept   = bus.IN_VALID && in_ready;
  assign sh_n     = bus.INPUTB[SHW-1:0];
  assign mul_sum  = acc_q + (work_q[0] ? mcand_q : '0);
  assign shl      = {work_q[WIDTH-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    work_d  = work_q;
    out_d   = out_q;
    hi_d    = hi_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    valid_d = valid_q && !bus.OUT_READY;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.OP == kMUL) begin
            state_d = MUL;
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, bus.INPUTA};
            work_d  = bus.INPUTB;
            cnt_d   = CW'(WIDTH - 1);
          end else if (bus.OP == kSHL_VAR && sh_n != '0) begin
            state_d = SHIFT;
            work_d  = bus.INPUTA;
            cnt_d   = CW'(sh_n) - CW'(1);
          end else begin
            out_d   = c_res;
            hi_d    = '0;
            carry_d = c_carry;
            zero_d  = c_zero;
            ovf_d   = c_ovf;
            valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d   = mul_sum;
        mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
        work_d  = {1'b0, work_q[WIDTH-1:1]};
        cnt_d   = cnt_q - CW'(1);
        // last iteration's sum goes straight to the output register
        if (cnt_q == '0) begin
          state_d = IDLE;
          out_d   = mul_sum[WIDTH-1:0];
          hi_d    = mul_sum[2*WIDTH-1:WIDTH];
          carry_d = 1'b0;
          zero_d  = (mul_sum == '0);
          ovf_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      SHIFT: begin
        work_d = shl;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
          out_d   = shl;
          hi_d    = '0;
          carry_d = work_q[WIDTH-1];
          zero_d  = (shl == '0);
          ovf_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      work_q  <= '0;
      out_q   <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      work_q  <= work_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = valid_q;
  assign bus.OUT       = out_q;
  assign bus.OUT_HI    = hi_q;
  assign bus.CARRY     = carry_q;
  assign bus.ZERO      = zero_q;
  assign bus.OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       c;
    logic       z;
    logic       o;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs [0:32];

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {valid, hi, out, carry, zero, ovf}
  function automatic logic [31:0] res_word();
    return {12'd0, bus.OUT_VALID, bus.OUT_HI, bus.OUT, bus.CARRY, bus.ZERO, bus.OVERFLOW};
  endfunction

  function automatic logic [31:0] exp_word(input logic [7:0] hi, input logic [7:0] out,
                                           input logic c, input logic z, input logic o);
    return {12'd0, 1'b1, hi, out, c, z, o};
  endfunction

  // present an op at the falling edge; returns 1 time unit after the accepting edge
  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge CLK);
    bus.OP       = op;
    bus.INPUTA   = a;
    bus.INPUTB   = b;
    bus.IN_VALID = 1'b1;
    #1 chk("in_ready", 32'(bus.IN_READY), 32'd1);
    @(posedge CLK);
    #1 bus.IN_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{4'd0,  8'h00, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0},
      '{4'd1,  8'h00, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0},
      '{4'd2,  8'h00, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0},
      '{4'd3,  8'h00, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0},
      '{4'd4,  8'h00, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0},
      '{4'd5,  8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0},
      '{4'd6,  8'h00, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b1},
      '{4'd7,  8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0},
      '{4'd8,  8'h00, 8'h5A, 8'h01, 1'b0, 1'b0, 1'b0},
      '{4'd9,  8'h00, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0},
      '{4'd10, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0},
      '{4'd11, 8'h00, 8'h5A, 8'hA6, 1'b1, 1'b0, 1'b0},
      '{4'd15, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b0},
      '{4'd14, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0},
      '{4'd1,  8'h96, 8'h00, 8'h2C, 1'b1, 1'b0, 1'b0},
      '{4'd2,  8'h96, 8'h00, 8'h4B, 1'b0, 1'b0, 1'b0},
      '{4'd2,  8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0},
      '{4'd3,  8'h96, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0},
      '{4'd3,  8'h5A, 8'h96, 8'h5A, 1'b0, 1'b0, 1'b0},
      '{4'd4,  8'h96, 8'h01, 8'h2D, 1'b0, 1'b0, 1'b0},
      '{4'd8,  8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0},
      '{4'd8,  8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1},
      '{4'd9,  8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b1},
      '{4'd11, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1},
      '{4'd5,  8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1},
      '{4'd0,  8'hC3, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0},
      '{4'd7,  8'h00, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0},
      '{4'd6,  8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0},
      '{4'd10, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0},
      '{4'd11, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0},
      '{4'd5,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0},
      '{4'd5,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1},
      '{4'd11, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0}
    };

    bus.IN_VALID  = 1'b0;
    bus.OP        = 4'd0;
    bus.INPUTA    = 8'h00;
    bus.INPUTB    = 8'h00;
    bus.OUT_READY = 1'b1;

    @(posedge CLK);
    #1;
    chk("reset_outputs", res_word(), 32'd0);
    chk("reset_in_ready", 32'(bus.IN_READY), 32'd1);
    @(negedge CLK);
    RESET = 1'b0;

    // back-to-back single-cycle stream, one result per accepting edge
    for (int i = 0; i < 33; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_op%0d", i, vecs[i].op), res_word(),
          exp_word(8'h00, vecs[i].out, vecs[i].c, vecs[i].z, vecs[i].o));
    end

    drive(kMUL, 8'hFF, 8'hFF);
    chk("mul_busy0", {30'd0, bus.IN_READY, bus.OUT_VALID}, 32'd0);
    for (int k = 1; k < 8; k++) begin
      @(posedge CLK);
      #1 chk($sformatf("mul_busy%0d", k), {30'd0, bus.IN_READY, bus.OUT_VALID}, 32'd0);
    end
    @(posedge CLK);
    #1 chk("mul_ff_ff", res_word(), exp_word(8'hFE, 8'h01, 1'b0, 1'b0, 1'b0));

    drive(kMUL, 8'h00, 8'h37);
    repeat (8) @(posedge CLK);
    #1 chk("mul_zero", res_word(), exp_word(8'h00, 8'h00, 1'b0, 1'b1, 1'b0));

    drive(kMUL, 8'h12, 8'h34);
    repeat (8) @(posedge CLK);
    #1 chk("mul_12_34", res_word(), exp_word(8'h03, 8'hA8, 1'b0, 1'b0, 1'b0));

    drive(kSHL_VAR, 8'h81, 8'h03);
    @(posedge CLK);
    #1 chk("shl3_wait1", 32'(bus.OUT_VALID), 32'd0);
    @(posedge CLK);
    #1 chk("shl3_wait2", 32'(bus.OUT_VALID), 32'd0);
    @(posedge CLK);
    #1 chk("shl3_result", res_word(), exp_word(8'h00, 8'h08, 1'b0, 1'b0, 1'b0));

    drive(kSHL_VAR, 8'h81, 8'h01);
    @(posedge CLK);
    #1 chk("shl1_result", res_word(), exp_word(8'h00, 8'h02, 1'b1, 1'b0, 1'b0));

    drive(kSHL_VAR, 8'h81, 8'h00);
    chk("shl0_result", res_word(), exp_word(8'h00, 8'h81, 1'b0, 1'b0, 1'b0));

    drive(kSHL_VAR, 8'h10, 8'h04);
    repeat (4) @(posedge CLK);
    #1 chk("shl4_result", res_word(), exp_word(8'h00, 8'h00, 1'b1, 1'b1, 1'b0));

    // back-pressure: result held, new issues ignored while stalled
    drive(kSUB, 8'h05, 8'h07);
    bus.OUT_READY = 1'b0;
    chk("bp_sub", res_word(), exp_word(8'h00, 8'hFE, 1'b1, 1'b0, 1'b0));
    bus.OP       = kCLEAR;
    bus.IN_VALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("bp_hold%0d", k), res_word(), exp_word(8'h00, 8'hFE, 1'b1, 1'b0, 1'b0));
      chk($sformatf("bp_in_ready%0d", k), 32'(bus.IN_READY), 32'd0);
    end
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    drive(kADD, 8'h01, 8'h02);
    chk("bp_release_add", res_word(), exp_word(8'h00, 8'h03, 1'b0, 1'b0, 1'b0));

    drive(kMUL, 8'h12, 8'h34);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #1 chk("rst_mid_mul", res_word(), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    #1 chk("rst_in_ready", 32'(bus.IN_READY), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK);
      #1 chk($sformatf("rst_no_valid%0d", k), 32'(bus.OUT_VALID), 32'd0);
    end

    drive(kADD, 8'h12, 8'h34);
    chk("post_reset_add", res_word(), exp_word(8'h00, 8'h46, 1'b0, 1'b0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
